quarter_wave_synth: RTL

Converts the phase accumulator's quadrant outputs into signed carrier samples. It takes the sample index (`idx_in`), quadrant mirror (`phase_in`) and half-wave sign (`sign_in`), reads a 64-entry quarter-wave sine ROM and applies symmetry and sign. Each 256-sample carrier period, optionally with BPSK polarity from a data-bit stream, becomes a sample stream for the DAC/output stage. It sits directly downstream of the phase accumulator.

---
 rtl/mod_pkg.sv | 39 +++
 rtl/sine_quarter_rom.sv | 22 ++
 rtl/quarter_wave_synth.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mod_pkg.sv
// Shared constants, sample type and quarter-wave sine table for the carrier synthesiser.
package mod_pkg;
  localparam int QUARTER_LEN = 64;
  localparam int ROM_W       = 7;
  localparam int AMP_W       = 8;
  localparam int AMP_MAX     = 127;

  typedef logic signed [AMP_W-1:0] sample_t;

  typedef enum logic {
    SYM_IDLE   = 1'b0,
    SYM_ACTIVE = 1'b1
  } sym_state_t;

  // Q[k] = round(127 * sin(pi * k / 128)), k = 0..63
  function automatic logic [ROM_W-1:0] quarter_sine(input int k);
    logic [ROM_W-1:0] q;
    case (k)
      0: q = 7'd0;    1: q = 7'd3;    2: q = 7'd6;    3: q = 7'd9;
      4: q = 7'd12;   5: q = 7'd16;   6: q = 7'd19;   7: q = 7'd22;
      8: q = 7'd25;   9: q = 7'd28;  10: q = 7'd31;  11: q = 7'd34;
     12: q = 7'd37;  13: q = 7'd40;  14: q = 7'd43;  15: q = 7'd46;
     16: q = 7'd49;  17: q = 7'd51;  18: q = 7'd54;  19: q = 7'd57;
     20: q = 7'd60;  21: q = 7'd63;  22: q = 7'd65;  23: q = 7'd68;
     24: q = 7'd71;  25: q = 7'd73;  26: q = 7'd76;  27: q = 7'd78;
     28: q = 7'd81;  29: q = 7'd83;  30: q = 7'd85;  31: q = 7'd88;
     32: q = 7'd90;  33: q = 7'd92;  34: q = 7'd94;  35: q = 7'd96;
     36: q = 7'd98;  37: q = 7'd100; 38: q = 7'd102; 39: q = 7'd104;
     40: q = 7'd106; 41: q = 7'd107; 42: q = 7'd109; 43: q = 7'd111;
     44: q = 7'd112; 45: q = 7'd113; 46: q = 7'd115; 47: q = 7'd116;
     48: q = 7'd117; 49: q = 7'd118; 50: q = 7'd120; 51: q = 7'd121;
     52: q = 7'd122; 53: q = 7'd122; 54: q = 7'd123; 55: q = 7'd124;
     56: q = 7'd125; 57: q = 7'd125; 58: q = 7'd126; 59: q = 7'd126;
     60: q = 7'd126; 61: q = 7'd127; 62: q = 7'd127; 63: q = 7'd127;
      default: q = 7'd0;
    endcase
    return q;
  endfunction
endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine ROM, unsigned magnitudes with a registered read port.
module sine_quarter_rom
  import mod_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [ROM_W-1:0]  data
);

  logic [ROM_W-1:0] rom_mem [2**ADDR_W];

  for (genvar gi = 0; gi < 2**ADDR_W; gi++) begin : g_rom_init
    assign rom_mem[gi] = quarter_sine(gi);
  end

  always_ff @(posedge clk) begin
    data <= rom_mem[addr];
  end

endmodule

// File: rtl/quarter_wave_synth.sv
// Quarter-wave carrier synthesiser: symmetry + sign from accumulator quadrants, optional BPSK.
// Optional feature macro: MOD_BPSK_EN (data handshake, symbol state, underrun pulse).
module quarter_wave_synth #(
  parameter int IDX_W = 6,
  parameter int AMP_W = mod_pkg::AMP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDX_W-1:0]        idx_in,
  input  logic                    phase_in,
  input  logic                    sign_in,
  input  logic                    data_valid,
  input  logic                    data_bit,
  output logic                    data_ready,
  output logic signed [AMP_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    underrun
);
  import mod_pkg::*;

  logic       boundary;
  sym_state_t state_next;
  logic       sym_next;
  logic       unr_now;

  assign boundary = (idx_in == '0) && !phase_in && !sign_in;

`ifdef MOD_BPSK_EN
  sym_state_t state_reg;
  logic       sym_reg;
  logic       transfer;

  assign data_ready = boundary;
  assign transfer   = data_valid && boundary;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SYM_IDLE;
      sym_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sym_reg   <= sym_next;
    end
  end

  // The symbol decided at a boundary already governs the boundary sample itself.
  always_comb begin
    state_next = state_reg;
    sym_next   = sym_reg;
    unr_now    = 1'b0;
    if (boundary) begin
      if (transfer) begin
        state_next = SYM_ACTIVE;
        sym_next   = data_bit;
      end else begin
        state_next = SYM_IDLE;
        sym_next   = 1'b0;
        unr_now    = 1'b1;
      end
    end
  end
`else
  logic unused_data;
  assign unused_data = data_valid ^ data_bit ^ boundary;
  assign data_ready  = 1'b0;
  assign state_next  = SYM_ACTIVE;
  assign sym_next    = 1'b0;
  assign unr_now     = 1'b0;
`endif

  logic [IDX_W-1:0] addr_reg;
  logic             neg_reg, idle_reg, unr_reg, valid_reg;
  logic             neg2_reg, idle2_reg, underrun_reg, valid2_reg;
  logic [ROM_W-1:0] rom_q;
  logic signed [AMP_W-1:0] mag;

  // Stage 1: mirror address, effective sign, idle flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      neg_reg   <= 1'b0;
      idle_reg  <= 1'b1;
      unr_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      addr_reg  <= phase_in ? ~idx_in : idx_in;
      neg_reg   <= sign_in ^ sym_next;
      idle_reg  <= (state_next == SYM_IDLE);
      unr_reg   <= unr_now;
      valid_reg <= 1'b1;
    end
  end

  sine_quarter_rom #(
    .ADDR_W (IDX_W)
  ) u_rom (
    .clk  (clk),
    .addr (addr_reg),
    .data (rom_q)
  );

  // Stage 2 control travels alongside the ROM's registered read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg2_reg     <= 1'b0;
      idle2_reg    <= 1'b1;
      underrun_reg <= 1'b0;
      valid2_reg   <= 1'b0;
    end else begin
      neg2_reg     <= neg_reg;
      idle2_reg    <= idle_reg;
      underrun_reg <= unr_reg;
      valid2_reg   <= valid_reg;
    end
  end

  assign mag          = $signed(AMP_W'(rom_q));
  assign sample_out   = (valid2_reg && !idle2_reg) ? (neg2_reg ? -mag : mag) : '0;
  assign sample_valid = valid2_reg;
  assign underrun     = underrun_reg;

endmodule
